adc_ltc2308_reader: RTL and testbench
=====================================

Name: adc_ltc2308_reader

Overview:
- Acquisition side of the ADC test core: the pattern side drives levels out, this block reads the LTC2308 12-bit SAR ADC on ADC_BUS back in.
- Scans channels 0..NUM_CH-1 continuously and issues tagged 12-bit samples.
- Sits in the emu top between the ADC_BUS pins (CONVST, SCK, SDI out; SDO in) and the on-screen display and level logic.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period (≥2); SCK = clk/(2*CLK_DIV).
- CONV_CYCLES, 80: clk cycles waited after CONVST for conversion (1.6 µs at 50 MHz).
- NUM_CH, 8: channels scanned (1..8).
- GAP_CYCLES, 4: idle clks between frames (acquisition time).

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high
- enable  in  1  1 = run continuous scan
- adc_convst  out  1  conversion start, ADC_BUS[0]
- adc_sck  out  1  serial clock, ADC_BUS[1]
- adc_sdi  out  1  config word to ADC, ADC_BUS[2]
- adc_sdo  in  1  data from ADC, ADC_BUS[3]
- sample_valid  out  1  one-clk strobe
- sample_data  out  12  unsigned result, MSB first as shifted
- sample_ch  out  3  channel the result belongs to
- busy  out  1  high in any state except IDLE
- peak_clear  in  1  clear peak registers (used only with ADC_MINMAX_EN)
- peak_min  out  12  minimum sample seen
- peak_max  out  12  maximum sample seen

Behaviour:
- Reset, synchronous, dominates everything: state=IDLE; adc_convst=0, adc_sck=0, adc_sdi=0; sample_valid=0, sample_data=0, sample_ch=0, busy=0; scan channel=0; prime flag=0.
- Reset mid-frame aborts immediately with no strobe.
- States:
  - IDLE: enable=1 → START.
  - START: adc_convst=1 for 2 clks → WAIT.
  - WAIT: adc_convst=0, count CONV_CYCLES → SHIFT.
  - SHIFT: 12 SCK pulses, each low CLK_DIV clks then high CLK_DIV clks, starting low → DONE.
  - DONE: 1 clk → GAP.
  - GAP: GAP_CYCLES clks, then START if enable=1, else IDLE.
- Config word, 6 bits, on SDI during SCK pulses 1-6, MSB first: {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}. SDI=0 for pulses 7-12.
- SDI changes at the start of each low phase and is stable across the SCK rising edge.
- SDO is sampled on the last clk of each high phase; bit 11 is sampled first.
- The LTC2308 applies the config to the next conversion, so frame N data belongs to the channel written in frame N-1:
  - keep prev_ch; sample_ch = prev_ch.
  - prev_ch ← cur_ch at DONE.
  - cur_ch ← (cur_ch == NUM_CH-1) ? 0 : cur_ch+1.
- Prime: the first frame after reset has undefined ADC config. Its sample_valid is suppressed and prime is set at its DONE. After a later IDLE the config is still valid and no suppression occurs.
- sample_valid pulses in the DONE clk when prime=1; sample_data and sample_ch update the same clk and hold until the next strobe.
- Frame period = 2 + CONV_CYCLES + 24*CLK_DIV + 1 + GAP_CYCLES clks; with defaults 2+80+96+1+4 = 183.
- enable deasserted mid-frame: the frame completes (strobe included), then IDLE. Re-assertion in GAP continues with no gap extension.
- NUM_CH=1: cur_ch stays 0.

Optional Feature:
- Macro ADC_MINMAX_EN.
- Defined:
  - peak_min/peak_max track every strobed sample: min ← min(min,data), max ← max(max,data).
  - reset or peak_clear loads min=12'hFFF, max=12'h000.
  - A peak_clear in the same clk as a strobe loads min=max=that sample.
- Undefined: peak_min=12'hFFF and peak_max=12'h000 constantly; peak_clear is ignored; no peak registers are built.

Decomposition:
- Package adc_pkg:
  - state enum {IDLE, START, WAIT, SHIFT, DONE, GAP}
  - ADC_BITS=12, CFG_BITS=6
  - config bit constants SD_SINGLE=1, UNI_UNIPOLAR=1, SLP_NAP=0
  - function building the 6-bit config from a 3-bit channel
- Sub-module adc_spi_shift holds the SCK divider, 12-bit bit counter, SDI shift-out and SDO shift-in. Interface: start/done handshake, cfg[5:0] in, data[11:0] out.

Test Plan:
- Reset, enable=1, ADC model returns 12'hA5C for ch0: first DONE produces no strobe; second frame strobes sample_ch=0, data=12'hA5C; strobe spacing 183 clks.
- NUM_CH=8, per-channel model values 0x100*ch: strobes show ch 0..7 then wrap to 0, data matching each ch; SDI words in frames 1-3 are 100010, 110010, 100110.
- SCK timing check at CLK_DIV=4: exactly 12 pulses per frame, 4 clks high and 4 low; adc_convst high exactly 2 clks; SDI stable ≥4 clks before each SCK rise.
- enable dropped mid-SHIFT: the strobe still occurs, busy falls after the GAP, and no further adc_convst; re-enable resumes at the next channel with no suppressed frame.
- reset asserted mid-SHIFT: the same clk gives sck=0 and convst=0, no strobe; after release the first frame is suppressed again.
- ADC_MINMAX_EN with samples 0x400, 0x050, 0xF00: peak_min=0x050, peak_max=0xF00; peak_clear coincident with a 0x321 strobe gives min=max=0x321.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the LTC2308 acquisition block.
// Holds the scan FSM states and the ADC config word builder.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SHIFT,
        DONE,
        GAP
    } state_t;

    localparam int ADC_BITS = 12;
    localparam int CFG_BITS = 6;

    localparam logic SD_SINGLE    = 1'b1;
    localparam logic UNI_UNIPOLAR = 1'b1;
    localparam logic SLP_NAP      = 1'b0;

    // LTC2308 input word: S/D, O/S, S1, S0, UNI, SLP
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
        return {SD_SINGLE, ch[0], ch[2], ch[1], UNI_UNIPOLAR, SLP_NAP};
    endfunction

endpackage

// File: rtl/adc_ltc2308_reader_if.sv
// ADC_BUS pins plus the tagged sample stream of the acquisition block.
// master = reader side, slave = pins/consumer side.
interface adc_ltc2308_reader_if;
    import adc_pkg::*;

    logic                adc_convst;
    logic                adc_sck;
    logic                adc_sdi;
    logic                adc_sdo;
    logic                sample_valid;
    logic [ADC_BITS-1:0] sample_data;
    logic [2:0]          sample_ch;

    modport master (
        output adc_convst, adc_sck, adc_sdi,
        output sample_valid, sample_data, sample_ch,
        input  adc_sdo
    );

    modport slave (
        input  adc_convst, adc_sck, adc_sdi,
        input  sample_valid, sample_data, sample_ch,
        output adc_sdo
    );

endinterface

// File: rtl/adc_spi_shift.sv
// SCK generator and 12-bit serial transfer: config out on SDI, data in on SDO.
// done is high in the last clk of the final high phase; data is valid then.
module adc_spi_shift
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CFG_BITS-1:0] cfg,
    input  logic                sdo,
    output logic                sck,
    output logic                sdi,
    output logic                done,
    output logic [ADC_BITS-1:0] data
);

    localparam int DW = $clog2(CLK_DIV);

    logic                active;
    logic                phase_hi;
    logic [DW-1:0]       div_cnt;
    logic [3:0]          bit_cnt;
    logic [CFG_BITS-2:0] cfg_sh;
    logic [ADC_BITS-2:0] data_sh;
    logic                phase_end;

    assign phase_end = active && (div_cnt == DW'(CLK_DIV - 1));
    assign done = phase_end && phase_hi && (bit_cnt == 4'(ADC_BITS - 1));
    assign data = {data_sh, sdo};

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            phase_hi <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            cfg_sh   <= '0;
            data_sh  <= '0;
            sck      <= 1'b0;
            sdi      <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            phase_hi <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sck      <= 1'b0;
            sdi      <= cfg[CFG_BITS-1];
            cfg_sh   <= cfg[CFG_BITS-2:0];
        end else if (active) begin
            div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
            if (phase_end) begin
                phase_hi <= !phase_hi;
                sck      <= !phase_hi;
                // end of high phase: capture SDO, present next SDI bit
                if (phase_hi) begin
                    data_sh <= data[ADC_BITS-2:0];
                    sdi     <= cfg_sh[CFG_BITS-2];
                    cfg_sh  <= {cfg_sh[CFG_BITS-3:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (done) active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/adc_ltc2308_reader.sv
// LTC2308 scan reader: continuous channel scan with tagged 12-bit samples.
// Define ADC_MINMAX_EN to build the peak_min/peak_max trackers.
module adc_ltc2308_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 80,
    parameter int NUM_CH      = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                peak_clear,
    output logic                busy,
    output logic [ADC_BITS-1:0] peak_min,
    output logic [ADC_BITS-1:0] peak_max,
    adc_ltc2308_reader_if.master bus
);

    state_t              state;
    logic [15:0]         cnt;
    logic [2:0]          cur_ch;
    logic [2:0]          prev_ch;
    logic                prime;
    logic                spi_start;
    logic                spi_done;
    logic [ADC_BITS-1:0] spi_data;

    assign spi_start = (state == WAIT) && (cnt == 16'(CONV_CYCLES - 1));

    adc_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk   (clk),
        .reset (reset),
        .start (spi_start),
        .cfg   (cfg_word(cur_ch)),
        .sdo   (bus.adc_sdo),
        .sck   (bus.adc_sck),
        .sdi   (bus.adc_sdi),
        .done  (spi_done),
        .data  (spi_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.adc_convst   <= 1'b0;
            bus.sample_valid <= 1'b0;
            bus.sample_data  <= '0;
            bus.sample_ch    <= '0;
            busy             <= 1'b0;
            cur_ch           <= '0;
            prev_ch          <= '0;
            prime            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (enable) begin
                    state          <= START;
                    cnt            <= '0;
                    bus.adc_convst <= 1'b1;
                    busy           <= 1'b1;
                end
                START: if (cnt == 16'd1) begin
                    state          <= WAIT;
                    cnt            <= '0;
                    bus.adc_convst <= 1'b0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                WAIT: if (spi_start) state <= SHIFT;
                      else cnt <= cnt + 16'd1;
                // data read now was converted with last frame's config
                SHIFT: if (spi_done) begin
                    state            <= DONE;
                    bus.sample_valid <= prime;
                    if (prime) begin
                        bus.sample_data <= spi_data;
                        bus.sample_ch   <= prev_ch;
                    end
                end
                DONE: begin
                    state            <= GAP;
                    cnt              <= '0;
                    bus.sample_valid <= 1'b0;
                    prime            <= 1'b1;
                    prev_ch          <= cur_ch;
                    cur_ch <= (cur_ch == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch + 3'd1;
                end
                GAP: if (cnt == 16'(GAP_CYCLES - 1)) begin
                    cnt <= '0;
                    if (enable) begin
                        state          <= START;
                        bus.adc_convst <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_MINMAX_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_min <= '1;
            peak_max <= '0;
        end else if (peak_clear) begin
            peak_min <= bus.sample_valid ? bus.sample_data : '1;
            peak_max <= bus.sample_valid ? bus.sample_data : '0;
        end else if (bus.sample_valid) begin
            if (bus.sample_data < peak_min) peak_min <= bus.sample_data;
            if (bus.sample_data > peak_max) peak_max <= bus.sample_data;
        end
    end
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak_min = '1;
    assign peak_max = '0;
`endif

endmodule

// File: tb/tb_adc_ltc2308_reader.sv
// Directed bench for adc_ltc2308_reader with a behavioural LTC2308 model.
// Peak checks follow ADC_MINMAX_EN.
module tb_adc_ltc2308_reader;
    import adc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        peak_clear = 1'b0;
    logic        busy;
    logic [11:0] peak_min;
    logic [11:0] peak_max;

    always #5 clk = ~clk;

    adc_ltc2308_reader_if bus();

    adc_ltc2308_reader dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .peak_clear (peak_clear),
        .busy       (busy),
        .peak_min   (peak_min),
        .peak_max   (peak_max),
        .bus        (bus)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // LTC2308 model: config from the previous frame selects this result
    logic [11:0] vals [8];
    logic [5:0]  cfg_sh = '0;
    logic [11:0] res = '0;
    logic [3:0]  idx = 4'd11;
    int          k = 0;
    int          cv_rises = 0;
    logic [5:0]  cfg_log [$];

    always @(posedge bus.adc_convst) begin
        res = vals[{cfg_sh[3], cfg_sh[2], cfg_sh[4]}];
        idx = 4'd11;
        k = 0;
        cv_rises++;
    end

    always @(posedge bus.adc_sck) begin
        if (k < 6) begin
            cfg_sh = {cfg_sh[4:0], bus.adc_sdi};
            if (k == 5) cfg_log.push_back(cfg_sh);
        end
        k++;
    end

    always @(negedge bus.adc_sck) if (idx != 4'd0) idx = idx - 4'd1;

    assign bus.adc_sdo = res[idx];

    // pin timing monitor
    bit   mon_clr = 1'b0;
    int   hi_run = 0, lo_run = 0, sdi_run = 0, cv_run = 0, np = 0;
    int   hi_bad = 0, lo_bad = 0, sdi_bad = 0, cv_bad = 0;
    logic p_sck, p_sdi, p_cv;

    always @(negedge clk) begin
        if (mon_clr) begin
            hi_bad = 0; lo_bad = 0; sdi_bad = 0; cv_bad = 0; np = 0;
        end else begin
            if (bus.adc_sck && !p_sck) begin
                if (np > 0 && lo_run != 4) lo_bad++;
                if (sdi_run < 4 || bus.adc_sdi != p_sdi) sdi_bad++;
                np++;
            end
            if (!bus.adc_sck && p_sck && hi_run != 4) hi_bad++;
            if (!bus.adc_convst && p_cv && cv_run != 2) cv_bad++;
            if (bus.adc_convst && !p_cv) np = 0;
        end
        hi_run  = bus.adc_sck ? ((p_sck === 1'b1) ? hi_run + 1 : 1) : 0;
        lo_run  = !bus.adc_sck ? ((p_sck === 1'b0) ? lo_run + 1 : 1) : 0;
        sdi_run = (bus.adc_sdi === p_sdi) ? sdi_run + 1 : 1;
        cv_run  = bus.adc_convst ? ((p_cv === 1'b1) ? cv_run + 1 : 1) : 0;
        p_sck = bus.adc_sck;
        p_sdi = bus.adc_sdi;
        p_cv  = bus.adc_convst;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_valid !== 1'b1 && n < 500);
        at = cyc;
        check("strobe_seen", {31'b0, bus.sample_valid}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t, cv0, lb;

        for (int i = 0; i < 8; i++) vals[i] = 12'h0F0 + 12'(i);
        vals[0] = 12'hA5C;

        tick(3);
        check("rst_convst", {31'b0, bus.adc_convst}, 0);
        check("rst_sck", {31'b0, bus.adc_sck}, 0);
        check("rst_sdi", {31'b0, bus.adc_sdi}, 0);
        check("rst_valid", {31'b0, bus.sample_valid}, 0);
        check("rst_data", {20'b0, bus.sample_data}, 0);
        check("rst_ch", {29'b0, bus.sample_ch}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_pmin", {20'b0, peak_min}, 32'hFFF);
        check("rst_pmax", {20'b0, peak_max}, 0);

        // first frame after reset is suppressed
        cv0 = cv_rises;
        enable = 1'b1;
        reset = 1'b0;
        wait_strobe(t0);
        check("t1_frames_to_first", cv_rises - cv0, 2);
        check("t1_ch", {29'b0, bus.sample_ch}, 0);
        check("t1_data", {20'b0, bus.sample_data}, 32'hA5C);
        wait_strobe(t1);
        check("t1_spacing", t1 - t0, 183);
        check("t1_ch2", {29'b0, bus.sample_ch}, 1);
        check("t1_data2", {20'b0, bus.sample_data}, 32'h0F1);

        // full scan with wrap, SDI words, pin timing
        for (int i = 0; i < 8; i++) vals[i] = 12'(i * 256);
        reset = 1'b1;
        enable = 1'b0;
        mon_clr = 1'b1;
        tick(3);
        mon_clr = 1'b0;
        lb = cfg_log.size();
        enable = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_strobe(t);
            check("t2_ch", {29'b0, bus.sample_ch}, 32'(i % 8));
            check("t2_data", {20'b0, bus.sample_data}, 32'((i % 8) * 256));
        end
        check("t2_pulses", np, 12);
        check("t2_sck_hi", hi_bad, 0);
        check("t2_sck_lo", lo_bad, 0);
        check("t2_sdi_setup", sdi_bad, 0);
        check("t2_convst_len", cv_bad, 0);
        check("t2_cfg1", {26'b0, cfg_log[lb]}, 32'b100010);
        check("t2_cfg2", {26'b0, cfg_log[lb + 1]}, 32'b110010);
        check("t2_cfg3", {26'b0, cfg_log[lb + 2]}, 32'b100110);

        // enable dropped mid-SHIFT
        tick(130);
        enable = 1'b0;
        wait_strobe(t);
        check("t4_ch", {29'b0, bus.sample_ch}, 1);
        check("t4_data", {20'b0, bus.sample_data}, 32'h100);
        tick(4);
        check("t4_busy_gap", {31'b0, busy}, 1);
        tick(1);
        check("t4_busy_idle", {31'b0, busy}, 0);
        cv0 = cv_rises;
        tick(300);
        check("t4_no_convst", cv_rises - cv0, 0);
        enable = 1'b1;
        wait_strobe(t);
        check("t4_resume_frames", cv_rises - cv0, 1);
        check("t4_resume_ch", {29'b0, bus.sample_ch}, 2);
        check("t4_resume_data", {20'b0, bus.sample_data}, 32'h200);

        // reset mid-SHIFT, during a high phase
        tick(133);
        check("t5_sck_pre", {31'b0, bus.adc_sck}, 1);
        reset = 1'b1;
        vals[0] = 12'h400;
        vals[1] = 12'h050;
        vals[2] = 12'hF00;
        vals[3] = 12'h321;
        tick(1);
        check("t5_sck", {31'b0, bus.adc_sck}, 0);
        check("t5_convst", {31'b0, bus.adc_convst}, 0);
        check("t5_valid", {31'b0, bus.sample_valid}, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_data", {20'b0, bus.sample_data}, 0);
        tick(2);
        cv0 = cv_rises;
        reset = 1'b0;
        wait_strobe(t);
        check("t5_prime_again", cv_rises - cv0, 2);
        check("t5_ch", {29'b0, bus.sample_ch}, 0);
        check("t5_data0", {20'b0, bus.sample_data}, 32'h400);

        // peak tracking
        wait_strobe(t);
        check("t6_data1", {20'b0, bus.sample_data}, 32'h050);
        wait_strobe(t);
        check("t6_data2", {20'b0, bus.sample_data}, 32'hF00);
        tick(2);
`ifdef ADC_MINMAX_EN
        check("t6_pmin", {20'b0, peak_min}, 32'h050);
        check("t6_pmax", {20'b0, peak_max}, 32'hF00);
`else
        check("t6_pmin", {20'b0, peak_min}, 32'hFFF);
        check("t6_pmax", {20'b0, peak_max}, 0);
`endif
        wait_strobe(t);
        peak_clear = 1'b1;
        check("t6_data3", {20'b0, bus.sample_data}, 32'h321);
        tick(1);
        peak_clear = 1'b0;
        tick(1);
`ifdef ADC_MINMAX_EN
        check("t6_clr_pmin", {20'b0, peak_min}, 32'h321);
        check("t6_clr_pmax", {20'b0, peak_max}, 32'h321);
`else
        check("t6_clr_pmin", {20'b0, peak_min}, 32'hFFF);
        check("t6_clr_pmax", {20'b0, peak_max}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
